// File: rtl/regfile_rw.sv
// MIPS register file: one write port, two combinational read ports with write-through bypass.
// A post-reset clear engine zeroes entries 1..R-1, one per cycle, while busy is high.
module regfile_rw #(
    parameter int N  = 32,
    parameter int R  = 32,
    parameter int AW = $clog2(R)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [N-1:0]  wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [N-1:0]  rd1,
    output logic [N-1:0]  rd2,
    output logic          busy
);

    // One-bit encoding so busy is the state flop itself, with no decode logic.
    typedef enum logic {
        READY = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [N-1:0]  mem [1:R-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= AW'(1);
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == AW'(R - 1))
                state <= READY;
        end
    end

    // NOTE: the array has no reset branch; it is zeroed by the clear engine so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                if (cnt != '0)
                    mem[cnt] <= '0;
            end else if (we && (wa != '0)) begin
                mem[wa] <= wd;
            end
        end
    end

    assign busy = (state == CLEAR);

    // Reads see rst only through busy; a same-cycle write is forwarded ahead of the array.
    assign rd1 = (busy || (ra1 == '0)) ? '0 :
                 (we && (wa == ra1))   ? wd : mem[ra1];
    assign rd2 = (busy || (ra2 == '0)) ? '0 :
                 (we && (wa == ra2))   ? wd : mem[ra2];

endmodule

// File: tb/tb_regfile_rw.sv
// Self-checking bench for regfile_rw: stimulus pushes expected outputs into a scoreboard,
// a negedge monitor pops and compares them against the DUT.
module tb_regfile_rw;

    localparam int N  = 32;
    localparam int R  = 32;
    localparam int AW = $clog2(R);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we  = 1'b0;
    logic [AW-1:0] wa  = '0;
    logic [N-1:0]  wd  = '0;
    logic [AW-1:0] ra1 = '0;
    logic [AW-1:0] ra2 = '0;
    logic [N-1:0]  rd1;
    logic [N-1:0]  rd2;
    logic          busy;

    regfile_rw #(.N(N), .R(R)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .wa   (wa),
        .wd   (wd),
        .ra1  (ra1),
        .ra2  (ra2),
        .rd1  (rd1),
        .rd2  (rd2),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: after any reset the whole file reads as zero, and the
    // file stays unavailable for clear_left more rising edges.
    logic [N-1:0] model_mem [R];
    int           clear_left = 0;
    bit           known      = 1'b0;

    logic         q_busy [$];
    logic [N-1:0] q_rd1  [$];
    logic [N-1:0] q_rd2  [$];
    string        q_tag  [$];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] model_read(input logic [AW-1:0] ra, input logic w,
                                                input logic [AW-1:0] a, input logic [N-1:0] d);
        if (clear_left > 0 || ra == 0) return '0;
        if (w && a == ra) return d;
        return model_mem[ra];
    endfunction

    // Drive one cycle of inputs, queue the expected outputs, then apply the edge to the model.
    task automatic cycle(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [N-1:0] d, input logic [AW-1:0] x1,
                         input logic [AW-1:0] x2, input string tag);
        rst = r; we = w; wa = a; wd = d; ra1 = x1; ra2 = x2;
        if (known) begin
            q_busy.push_back(clear_left > 0);
            q_rd1.push_back(model_read(x1, w, a, d));
            q_rd2.push_back(model_read(x2, w, a, d));
            q_tag.push_back(tag);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < R; i++) model_mem[i] = '0;
            clear_left = R - 1;
            known      = 1'b1;
        end else if (clear_left > 0) begin
            clear_left--;
        end else if (w && a != 0) begin
            model_mem[a] = d;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (q_busy.size() > 0) begin
            string        t;
            logic         eb;
            logic [N-1:0] e1;
            logic [N-1:0] e2;
            t  = q_tag.pop_front();
            eb = q_busy.pop_front();
            e1 = q_rd1.pop_front();
            e2 = q_rd2.pop_front();
            check({t, " busy"}, N'(busy), N'(eb));
            check({t, " rd1"}, rd1, e1);
            check({t, " rd2"}, rd2, e2);
        end
    end

    function automatic logic [AW-1:0] rnd_addr();
        return AW'($urandom_range(0, R - 1));
    endfunction

    initial begin
        @(posedge clk);
        #1;

        // Reset held for three cycles, then the 31-cycle clear with a dropped write at cycle 5.
        repeat (3) cycle(1'b1, 1'b0, '0, '0, rnd_addr(), rnd_addr(), "reset");
        for (int i = 1; i <= R - 1; i++)
            cycle(1'b0, i == 5, AW'(7), 32'hDEADBEEF, AW'(7), rnd_addr(), "clear");

        for (int i = 0; i < R; i++)
            cycle(1'b0, 1'b0, '0, '0, AW'(i), AW'(R - 1 - i), "sweep");

        // Bypass then array read of the same entry on both ports.
        cycle(1'b0, 1'b1, AW'(9), 32'h12345678, AW'(9), AW'(9), "bypass9");
        cycle(1'b0, 1'b0, AW'(9), '0, AW'(9), AW'(9), "read9");

        // Register zero ignores writes.
        cycle(1'b0, 1'b1, AW'(0), 32'hFFFFFFFF, AW'(0), AW'(0), "zero_wr");
        repeat (3) cycle(1'b0, 1'b0, '0, '0, AW'(0), rnd_addr(), "zero_rd");

        // Reset mid-clear restarts a full clear.
        cycle(1'b1, 1'b0, '0, '0, AW'(9), AW'(9), "rst_a");
        repeat (19) cycle(1'b0, 1'b0, '0, '0, AW'(9), rnd_addr(), "clear_a");
        cycle(1'b1, 1'b0, '0, '0, AW'(9), AW'(9), "rst_mid");
        repeat (R - 1) cycle(1'b0, 1'b0, '0, '0, AW'(9), rnd_addr(), "clear_b");

        // Write coincident with reset is dropped.
        cycle(1'b1, 1'b1, AW'(3), 32'hA5A5A5A5, AW'(3), AW'(3), "rst_wr");
        repeat (R - 1) cycle(1'b0, 1'b0, '0, '0, AW'(3), rnd_addr(), "clear_c");
        cycle(1'b0, 1'b0, '0, '0, AW'(3), AW'(3), "read3");

        // Dual-port independence with a bypass on one port only.
        cycle(1'b0, 1'b1, AW'(4), 32'h11, AW'(4), AW'(5), "wr4");
        cycle(1'b0, 1'b1, AW'(5), 32'h22, AW'(4), AW'(5), "wr5");
        cycle(1'b0, 1'b1, AW'(4), 32'h33, AW'(5), AW'(4), "dual");
        cycle(1'b0, 1'b0, '0, '0, AW'(5), AW'(4), "dual_after");

        // Randomized traffic with occasional resets; read addresses biased toward wa.
        for (int i = 0; i < 400; i++) begin
            logic          r;
            logic          w;
            logic [AW-1:0] a;
            logic [AW-1:0] x1;
            logic [AW-1:0] x2;
            r  = ($urandom_range(0, 99) == 0);
            w  = ($urandom_range(0, 2) != 0);
            a  = rnd_addr();
            x1 = ($urandom_range(0, 3) == 0) ? a : rnd_addr();
            x2 = ($urandom_range(0, 3) == 0) ? a : rnd_addr();
            cycle(r, w, a, N'($urandom), x1, x2, "random");
        end

        rst = 1'b0; we = 1'b0;
        repeat (2) @(posedge clk);
        check("scoreboard drain", N'(q_busy.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
